// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX dispatch queue: packed micro-op layout,
// opcode constants and the bubble test used at the queue input.
package id_ex_pkg;

    // Packed micro-op width and field layout (LSB offsets and widths).
    localparam int UOP_W       = 103;

    localparam int OPC_LSB     = 0;
    localparam int OPC_W       = 7;
    localparam int F3_LSB      = 7;
    localparam int F3_W        = 3;
    localparam int F7_LSB      = 10;
    localparam int F7_W        = 7;
    localparam int RS1_LSB     = 17;
    localparam int RS2_LSB     = 22;
    localparam int RD_LSB      = 27;
    localparam int REG_W       = 5;
    localparam int IMM_LSB     = 32;
    localparam int IMM_W       = 32;
    localparam int LWSW_LSB    = 64;
    localparam int LWSW_W      = 2;
    localparam int REGWR_BIT   = 66;
    localparam int MEMRD_BIT   = 67;
    localparam int MEMWR_BIT   = 68;
    localparam int MEM2REG_BIT = 69;
    localparam int HASIMM_BIT  = 70;
    localparam int PC_LSB      = 71;
    localparam int PC_W        = 32;

    // Major opcodes seen by the queue; an all-zero opcode marks a bubble.
    typedef enum logic [OPC_W-1:0] {
        OPC_BUBBLE = 7'h00,
        OPC_LOAD   = 7'h03,
        OPC_OP_IMM = 7'h13,
        OPC_AUIPC  = 7'h17,
        OPC_STORE  = 7'h23,
        OPC_OP     = 7'h33,
        OPC_LUI    = 7'h37,
        OPC_BRANCH = 7'h63,
        OPC_JALR   = 7'h67,
        OPC_JAL    = 7'h6F
    } opcode_e;

    // A bubble is handshaken away at the input but never occupies an entry.
    function automatic logic is_bubble(input logic [OPC_W-1:0] opc);
        return opc == OPC_BUBBLE;
    endfunction

endpackage

// File: rtl/id_ex_dispatch_queue.sv
// In-order DEPTH-entry micro-op FIFO between decode and dispatch.
// Bubbles are accepted but dropped, stall freezes the head, flush empties
// the queue. Head data is read from the registered array (no bypass).
module id_ex_dispatch_queue #(
    parameter int UOP_W = id_ex_pkg::UOP_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [UOP_W-1:0]           uop_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [UOP_W-1:0]           uop_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       is_dispatching
);
    import id_ex_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 1);

    logic [UOP_W-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_next;
    logic             bubble;
    logic             push;
    logic             pop;
    logic             empty;

    assign empty          = (count == '0);
    assign bubble         = is_bubble(uop_in[OPC_LSB +: OPC_W]);
    assign in_ready       = (count != FULL_CNT);
    assign almost_full    = (count >= AFULL_CNT);
    assign push           = in_valid & in_ready & ~bubble & ~flush;
    assign out_valid      = ~empty & ~stall & ~flush;
    assign pop            = out_valid & out_ready;
    assign is_dispatching = pop;

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Head presentation: zero when empty, otherwise the stored entry at rd_ptr.
    always_comb begin
        uop_out = '0;
        if (!empty) begin
            uop_out = mem[rd_ptr];
        end
    end

    // Pointer and count state; reset outranks flush, flush outranks push/pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Entry storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; count gates visibility, so stale contents are never observed.
        if (push) begin
            mem[wr_ptr] <= uop_in;
        end
    end

    // Occupancy never exceeds DEPTH and a push only happens with room.
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= FULL_CNT);
    a_push_ready:  assert property (@(posedge clk) disable iff (rst) push |-> in_ready);
    a_pop_nonempty: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);

endmodule
